axi4_mem_slave: RTL
===================

Name: axi4_mem_slave

Overview:
AXI4 responder (slave end) that terminates master-side AW/W/AR traffic in an on-chip word-addressed memory. It returns B and R responses. The block serves as the default memory target for the core's AXI4 master ports in simulation and FPGA builds. Independent write and read engines support FIXED/INCR bursts up to 256 beats.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width in bits (multiple of 8)
ID_W, 4, transaction ID width
DEPTH_WORDS, 1024, memory size in DATA_W words
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to DEPTH_WORDS*DATA_W/8)

Ports:
ACLK in 1 clock
ARESETn in 1 asynchronous active-low reset
AWID in ID_W; AWADDR in ADDR_W; AWLEN in 8; AWSIZE in 3; AWBURST in 2; AWVALID in 1; AWREADY out 1
WDATA in DATA_W; WSTRB in DATA_W/8; WLAST in 1; WVALID in 1; WREADY out 1
BID out ID_W; BRESP out 2; BVALID out 1; BREADY in 1
ARID in ID_W; ARADDR in ADDR_W; ARLEN in 8; ARSIZE in 3; ARBURST in 2; ARVALID in 1; ARREADY out 1
RID out ID_W; RDATA out DATA_W; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1

Behaviour:
- One clock, ACLK. ARESETn is asynchronous and active-low. All outputs are registered.
- Reset values: every READY/VALID output is 0; BID, BRESP, RID, RDATA, RRESP and RLAST are 0. Both FSMs go to IDLE. Memory contents are not reset.
- AWREADY and ARREADY rise 1 in the first cycle after ARESETn deasserts.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: AWREADY=1. On AW handshake, capture ID, word-aligned address, LEN, BURST and error state. Drop AWREADY and go to W_DATA with WREADY=1 the next cycle.
  - W_DATA: on each W handshake, write lanes selected by WSTRB if the beat has no error. For INCR, advance the address by DATA_W/8; for FIXED, hold it. Increment the beat counter.
  - On a W handshake with WLAST=1, go to W_RESP: WREADY=0, BVALID=1, BID=captured ID.
  - W_RESP: hold BVALID and payload until BREADY. Then go to W_IDLE with AWREADY=1 the following cycle.
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: ARREADY=1. On AR handshake, capture the fields and go to R_FETCH.
  - R_FETCH: issue the synchronous memory read (1-cycle latency), then go to R_DATA.
  - R_DATA: RVALID=1 with RDATA, RRESP, RID, and RLAST=(beat==LEN). Hold until RREADY.
  - After the handshake: if it was the last beat go to R_IDLE, else advance the address and go to R_FETCH.
  - Throughput is one beat per 2 cycles minimum.
- Error rules (resp codes: OKAY 00, SLVERR 10, DECERR 11):
  - SLVERR if SIZE != log2(DATA_W/8), or BURST is WRAP/reserved. The whole burst is affected: no writes, RDATA=0.
  - SLVERR if the W beat count != AWLEN+1 at WLAST. Beats already written stay written.
  - DECERR per beat if the beat address is outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*DATA_W/8). That beat is not written; on reads, RDATA=0.
  - BRESP is the sticky first error of the burst (SLVERR beats DECERR if both occur). RRESP is per beat.
- Beats beyond 256 without WLAST are still accepted until WLAST and are not written; BRESP=SLVERR.
- Simultaneous read and write to the same word in the same cycle: the read returns the old data.
- The write and read engines are fully independent; no ordering between them is guaranteed.
- Reset asserted mid-burst: the FSMs abort immediately to reset values. Memory keeps partially written data.

Decomposition:
- Add to the shared axi4 package:
  - width constants AXI_ID_W, AXI_ADDR_W, AXI_DATA_W
  - LEN (8), SIZE (3), BURST (2) and RESP (2) field widths in the aw/ar/b/r structs
  - resp localparams RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR
  - burst localparams BURST_FIXED, BURST_INCR, BURST_WRAP
- Sub-module axi4_mem_sram: 1 write port with byte enables plus 1 synchronous read port, DEPTH_WORDS x DATA_W.

Test Plan:
- Single write: AW addr 0x10, WDATA 0xDEADBEEF, WSTRB 0xF, BREADY=1 -> BVALID 1 with BRESP 00. Then AR 0x10 -> RDATA 0xDEADBEEF, RRESP 00, RLAST 1.
- INCR burst: AWLEN=3 at 0x100 with data 1..4, then ARLEN=3 at 0x100 -> 4 R beats 1,2,3,4; RLAST only on the 4th; RID echoes ARID=0x5.
- Partial strobe: preload 0x11223344, write 0xAABBCCDD with WSTRB=0b0101 -> readback 0x11BB33DD.
- Out of range: write/read at BASE_ADDR+DEPTH_WORDS*4 -> BRESP 11, RRESP 11, RDATA 0, memory unchanged. AWBURST=WRAP -> BRESP 10.
- Backpressure: hold BREADY/RREADY=0 for 5 cycles -> BVALID/RVALID and payload stable, AWREADY/ARREADY stay 0. Release -> handshake completes, READY returns 1 the next cycle.
- Reset mid-burst: assert ARESETn=0 after 2 of 4 W beats -> WREADY, BVALID, RVALID 0 asynchronously. After release -> AWREADY=1, and a new transaction completes normally.

Source files
------------

// File: rtl/axi4_mem_slave_pkg.sv
// Shared AXI4 types and constants for the on-chip memory responder.
// Latency: n/a (types, constants and a pure response-merge helper).
// Backpressure: n/a.
package axi4_mem_slave_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_EXOKAY = 2'b01;
  localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;
  localparam logic [BURST_W-1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
    logic [SIZE_W-1:0]     size;
    logic [BURST_W-1:0]    burst;
  } aw_t;

  typedef aw_t ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [RESP_W-1:0]   resp;
  } b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [RESP_W-1:0]     resp;
    logic                  last;
  } r_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

  // WRAP and the reserved encoding are not supported by this responder.
  function automatic logic burst_bad(input logic [BURST_W-1:0] b);
    return b >= BURST_WRAP;
  endfunction

  // Sticky burst response: SLVERR dominates, otherwise the first error wins.
  function automatic logic [RESP_W-1:0] resp_merge(input logic [RESP_W-1:0] acc,
                                                   input logic [RESP_W-1:0] beat);
    if (acc == RESP_SLVERR || beat == RESP_SLVERR) return RESP_SLVERR;
    if (acc == RESP_OKAY || acc == RESP_EXOKAY) return beat;
    return acc;
  endfunction

endpackage

// File: rtl/axi4_mem_sram.sv
// Word memory with one byte-enabled write port and one synchronous read port.
// Latency: read data registered 1 cycle after re_i; rclr_i loads zero instead.
// Backpressure: none; the caller owns all flow control.
// Ports: clk_i/rst_ni, write (we_i, be_i, waddr_i, wdata_i), read (re_i, rclr_i, raddr_i, rdata_o).
module axi4_mem_sram #(
  parameter int  DATA_W      = 32,
  parameter int  DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS),
  localparam int BYTES       = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [BYTES-1:0]  be_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rclr_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Array is never reset so contents survive ARESETn.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read-before-write on a same-word collision falls out of the NBA ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= rclr_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 responder terminating AW/W/AR traffic in on-chip SRAM, FIXED/INCR bursts up to 256 beats.
// Latency: AW accept -> WREADY next cycle; WLAST -> BVALID next cycle; AR -> R beat every 2 cycles.
// Backpressure: B/R held stable until BREADY/RREADY; AW/AR refused while the engine's burst is open.
// Ports: ACLK, ARESETn, AW*/W*/B* write channels, AR*/R* read channels (standard AXI4 names).
module axi4_mem_slave
  import axi4_mem_slave_pkg::*;
#(
  parameter int              ADDR_W      = AXI_ADDR_W,
  parameter int              DATA_W      = AXI_DATA_W,
  parameter int              ID_W        = AXI_ID_W,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [SIZE_W-1:0]   AWSIZE,
  input  logic [BURST_W-1:0]  AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [RESP_W-1:0]   BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [SIZE_W-1:0]   ARSIZE,
  input  logic [BURST_W-1:0]  ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [RESP_W-1:0]   RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int                BYTES      = DATA_W / 8;
  localparam int                OFF_W      = $clog2(BYTES);
  localparam int                IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   MEM_BYTES  = (ADDR_W+1)'(DEPTH_WORDS * BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTES);
  localparam logic [SIZE_W-1:0] FULL_SIZE  = SIZE_W'(OFF_W);

  // Offset compare also rejects addresses below BASE_ADDR (they wrap to huge offsets).
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return {1'b0, off} < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  // ---------------- write engine ----------------
  wr_state_e         wstate_q, wstate_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0]   bid_q, bid_d;
  logic [RESP_W-1:0] bresp_q, bresp_d, w_beat_resp;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [LEN_W-1:0]  wlen_q, wlen_d;
  logic              wfixed_q, wfixed_d, wslv_q, wslv_d;
  logic [8:0]        wcnt_q, wcnt_d;   // saturates at 256 so overlong bursts never alias
  logic              mem_we;

  always_comb begin
    wstate_d = wstate_q;  awready_d = awready_q; wready_d = wready_q;
    bvalid_d = bvalid_q;  bid_d = bid_q;         bresp_d = bresp_q;
    waddr_d  = waddr_q;   wlen_d = wlen_q;       wfixed_d = wfixed_q;
    wslv_d   = wslv_q;    wcnt_d = wcnt_q;
    w_beat_resp = RESP_OKAY;
    mem_we      = 1'b0;
    unique case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wstate_d  = W_DATA;
          bid_d     = AWID;
          waddr_d   = AWADDR & ALIGN_MASK;
          wlen_d    = AWLEN;
          wfixed_d  = (AWBURST == BURST_FIXED);
          wslv_d    = (AWSIZE != FULL_SIZE) || burst_bad(AWBURST);
          wcnt_d    = '0;
          bresp_d   = wslv_d ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_DATA: begin
        if (WVALID && wready_q) begin
          // Beats past AWLEN are swallowed unwritten; the WLAST check flags them.
          mem_we = !wslv_q && in_range(waddr_q) && (wcnt_q <= {1'b0, wlen_q});
          if (!in_range(waddr_q)) w_beat_resp = RESP_DECERR;
          if (WLAST && (wcnt_q != {1'b0, wlen_q})) w_beat_resp = RESP_SLVERR;
          bresp_d = resp_merge(bresp_q, w_beat_resp);
          if (!wfixed_q) waddr_d = waddr_q + STEP;
          if (wcnt_q != 9'd256) wcnt_d = wcnt_q + 9'd1;
          if (WLAST) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wstate_q <= W_IDLE; awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0;
      bid_q    <= '0;     bresp_q   <= '0;   waddr_q  <= '0;   wlen_q   <= '0;
      wfixed_q <= 1'b0;   wslv_q    <= 1'b0; wcnt_q   <= '0;
    end else begin
      wstate_q <= wstate_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      bid_q    <= bid_d;    bresp_q   <= bresp_d;   waddr_q  <= waddr_d;  wlen_q   <= wlen_d;
      wfixed_q <= wfixed_d; wslv_q    <= wslv_d;    wcnt_q   <= wcnt_d;
    end
  end

  // ---------------- read engine ----------------
  rd_state_e         rstate_q, rstate_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [RESP_W-1:0] rresp_q, rresp_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic              rfixed_q, rfixed_d, rslv_q, rslv_d;
  logic              mem_re, mem_rclr;

  always_comb begin
    rstate_d = rstate_q; arready_d = arready_q; rvalid_d = rvalid_q; rlast_d = rlast_q;
    rid_d    = rid_q;    rresp_d   = rresp_q;   raddr_d  = raddr_q;  rlen_d  = rlen_q;
    rcnt_d   = rcnt_q;   rfixed_d  = rfixed_q;  rslv_d   = rslv_q;
    mem_re   = 1'b0;
    mem_rclr = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ARVALID && arready_q) begin
          arready_d = 1'b0;
          rstate_d  = R_FETCH;
          rid_d     = ARID;
          raddr_d   = ARADDR & ALIGN_MASK;
          rlen_d    = ARLEN;
          rcnt_d    = '0;
          rfixed_d  = (ARBURST == BURST_FIXED);
          rslv_d    = (ARSIZE != FULL_SIZE) || burst_bad(ARBURST);
        end
      end
      R_FETCH: begin
        // Errored beats load zero into the read register instead of array data.
        mem_re   = 1'b1;
        mem_rclr = rslv_q || !in_range(raddr_q);
        rresp_d  = rslv_q ? RESP_SLVERR : (in_range(raddr_q) ? RESP_OKAY : RESP_DECERR);
        rlast_d  = (rcnt_q == rlen_q);
        rvalid_d = 1'b1;
        rstate_d = R_DATA;
      end
      R_DATA: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end else begin
            rcnt_d   = rcnt_q + 8'd1;
            if (!rfixed_q) raddr_d = raddr_q + STEP;
            rstate_d = R_FETCH;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rstate_q <= R_IDLE; arready_q <= 1'b0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
      rid_q    <= '0;     rresp_q   <= '0;   raddr_q  <= '0;   rlen_q  <= '0;
      rcnt_q   <= '0;     rfixed_q  <= 1'b0; rslv_q   <= 1'b0;
    end else begin
      rstate_q <= rstate_d; arready_q <= arready_d; rvalid_q <= rvalid_d; rlast_q <= rlast_d;
      rid_q    <= rid_d;    rresp_q   <= rresp_d;   raddr_q  <= raddr_d;  rlen_q  <= rlen_d;
      rcnt_q   <= rcnt_d;   rfixed_q  <= rfixed_d;  rslv_q   <= rslv_d;
    end
  end

  axi4_mem_sram #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk_i   (ACLK),
    .rst_ni  (ARESETn),
    .we_i    (mem_we),
    .be_i    (WSTRB),
    .waddr_i (word_idx(waddr_q)),
    .wdata_i (WDATA),
    .re_i    (mem_re),
    .rclr_i  (mem_rclr),
    .raddr_i (word_idx(raddr_q)),
    .rdata_o (RDATA)
  );

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BID     = bid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RID     = rid_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule
